hazard_fwd_unit: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It tracks the destination register and write/load status of the instructions in EX, MEM and WB, and generates the registered select codes for the two EX-stage operand muxes. It detects load-use hazards and stalls IF/ID for the required cycles, inserting a bubble into EX. It sits beside the ID/EX pipeline register and drives the select inputs of the cascaded 32-bit operand muxes.

---
 rtl/hazard_fwd_unit.sv | 142 ++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use hazard detection and EX operand forwarding select generation for the
// 5-stage MIPS pipeline. Tracks the destination register and write/load status of the EX, MEM
// and WB instructions.
// Build option: define HAZ_FWD_EN for full forwarding (stall only on load-use). Without it the
// forwarding selects are tied to regfile and any EX/MEM dependency stalls until the producer
// reaches WB.
module hazard_fwd_unit #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [4:0]             id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   flush,
  output logic                   stall,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [1:0] SelRegFile = 2'b00;
  localparam logic [1:0] SelExMem   = 2'b01;
  localparam logic [1:0] SelMemWb   = 2'b10;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       load;
  } slot_t;

  slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic ex_prod, mem_prod;
  logic match_ex_a, match_ex_b, match_mem_a, match_mem_b;
  logic hazard, advance;

  // A slot is a producer only when it writes a non-zero register; $0 never forwards.
  assign ex_prod  = ex_q.wr && (ex_q.rd != 5'd0);
  assign mem_prod = mem_q.wr && (mem_q.rd != 5'd0);

  assign match_ex_a  = id_uses_rs && ex_prod && (id_rs == ex_q.rd);
  assign match_ex_b  = id_uses_rt && ex_prod && (id_rt == ex_q.rd);
  assign match_mem_a = id_uses_rs && mem_prod && (id_rs == mem_q.rd);
  assign match_mem_b = id_uses_rt && mem_prod && (id_rt == mem_q.rd);

`ifdef HAZ_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign hazard = ex_q.load && (match_ex_a || match_ex_b);
`else
  // No bypass paths: wait until the producer reaches WB (write-before-read regfile).
  assign hazard = match_ex_a || match_ex_b || match_mem_a || match_mem_b;
`endif

  // Flush discards the ID instruction, so it also cancels any stall.
  assign stall   = id_valid && !flush && hazard;
  assign advance = id_valid && !flush && !hazard;

  // Slot shift: WB <- MEM <- EX <- ID instruction or bubble.
  always_comb begin
    wb_d  = mem_q;
    mem_d = ex_q;
    ex_d  = '0;
    if (advance) begin
      ex_d.rd   = id_rd;
      ex_d.wr   = id_reg_write;
      ex_d.load = id_mem_read;
    end
  end

  // Saturating count of stall cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end
  end

  // Slot and counter state, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

`ifdef HAZ_FWD_EN
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  // Select codes computed in ID; the youngest producer (EX) wins over MEM. Bubbles get regfile.
  always_comb begin
    fwd_a_d = SelRegFile;
    fwd_b_d = SelRegFile;
    if (advance) begin
      if (match_ex_a)       fwd_a_d = SelExMem;
      else if (match_mem_a) fwd_a_d = SelMemWb;
      if (match_ex_b)       fwd_b_d = SelExMem;
      else if (match_mem_b) fwd_b_d = SelMemWb;
    end
  end

  // Select registers move with the instruction into EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a_q <= SelRegFile;
      fwd_b_q <= SelRegFile;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
`else
  assign fwd_a_sel = SelRegFile;
  assign fwd_b_sel = SelRegFile;

  logic [3:0] unused_sel_codes;
  assign unused_sel_codes = {SelExMem, SelMemWb};
`endif

  // WB contents and load flags past EX are tracked but feed no decision.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{wb_q, mem_q.load, ex_q.load};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit. Expectations follow HAZ_FWD_EN when it is defined,
// the no-forwarding behaviour otherwise.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush;
  logic        stall;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_count;

  hazard_fwd_unit #(.STALL_CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_rd       (id_rd),
    .id_reg_write(id_reg_write),
    .id_mem_read (id_mem_read),
    .flush       (flush),
    .stall       (stall),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       es;
    logic [1:0] ea;
    logic [1:0] eb;
  } row_t;

  typedef struct {
    string       name;
    logic [20:0] val;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt = '0;

  function automatic row_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic [4:0] rd, logic rw, logic mr, logic fl, logic es,
                              logic [1:0] ea, logic [1:0] eb);
    row_t r;
    r = '{rst: 1'b0, v: v, rs: rs, rt: rt, urs: urs, urt: urt, rd: rd, rw: rw, mr: mr, fl: fl,
          es: es, ea: ea, eb: eb};
    return r;
  endfunction

  function automatic row_t idle(logic [1:0] ea, logic [1:0] eb);
    return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb);
  endfunction

  // Applies one row's ID inputs and pushes the expected outputs for that cycle.
  task automatic drive(input row_t r, input string nm);
    exp_t e;
    reset        = r.rst;
    id_valid     = r.v;
    id_rs        = r.rs;
    id_rt        = r.rt;
    id_uses_rs   = r.urs;
    id_uses_rt   = r.urt;
    id_rd        = r.rd;
    id_reg_write = r.rw;
    id_mem_read  = r.mr;
    flush        = r.fl;
    e.name = nm;
    e.val  = {r.es, r.ea, r.eb, exp_cnt};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    row_t t[$];
    exp_t e;
    reset = 1'b1;
    drive(idle(2'b00, 2'b00), "pre");
    void'(sb.pop_front());
    repeat (2) @(posedge clk);
    t.push_back(idle(2'b00, 2'b00));
    t.push_back(mk(1, 5'd3, 5'd3, 1, 1, 5'd5, 1, 1, 0, 0, 2'b00, 2'b00));
    t.push_back(idle(2'b00, 2'b00));
    t.push_back(idle(2'b00, 2'b00));
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i], $sformatf("reset[%0d]", i));
      #1;
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_a_sel, fwd_b_sel, stall_count} !== e.val) begin
        miscompares++;
        $display("FAIL %s: got stall=%b a=%b b=%b cnt=%0d want stall=%b a=%b b=%b cnt=%0d",
                 e.name, stall, fwd_a_sel, fwd_b_sel, stall_count,
                 e.val[20], e.val[19:18], e.val[17:16], e.val[15:0]);
      end
      if (t[i].rst) exp_cnt = '0;
      else if (t[i].es) exp_cnt++;
    end
  endtask

  // add $3,$1,$2 ; sub $4,$3,$5
  task automatic test_alu_fwd();
    row_t t[$];
    exp_t e;
    t.push_back(mk(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00));
`ifdef HAZ_FWD_EN
    t.push_back(mk(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(idle(2'b01, 2'b00));
`else
    t.push_back(mk(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 1, 2'b00, 2'b00));
    t.push_back(mk(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 1, 2'b00, 2'b00));
    t.push_back(mk(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(idle(2'b00, 2'b00));
`endif
    t.push_back(idle(2'b00, 2'b00));
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i], $sformatf("alu_fwd[%0d]", i));
      #1;
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_a_sel, fwd_b_sel, stall_count} !== e.val) begin
        miscompares++;
        $display("FAIL %s: got stall=%b a=%b b=%b cnt=%0d want stall=%b a=%b b=%b cnt=%0d",
                 e.name, stall, fwd_a_sel, fwd_b_sel, stall_count,
                 e.val[20], e.val[19:18], e.val[17:16], e.val[15:0]);
      end
      if (t[i].rst) exp_cnt = '0;
      else if (t[i].es) exp_cnt++;
    end
  endtask

  // lw $3,0($1) ; add $4,$2,$3
  task automatic test_load_use();
    row_t t[$];
    exp_t e;
    t.push_back(mk(1, 5'd1, 5'd3, 1, 0, 5'd3, 1, 1, 0, 0, 2'b00, 2'b00));
    t.push_back(mk(1, 5'd2, 5'd3, 1, 1, 5'd4, 1, 0, 0, 1, 2'b00, 2'b00));
`ifdef HAZ_FWD_EN
    t.push_back(mk(1, 5'd2, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(idle(2'b00, 2'b10));
`else
    t.push_back(mk(1, 5'd2, 5'd3, 1, 1, 5'd4, 1, 0, 0, 1, 2'b00, 2'b00));
    t.push_back(mk(1, 5'd2, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(idle(2'b00, 2'b00));
`endif
    t.push_back(idle(2'b00, 2'b00));
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i], $sformatf("load_use[%0d]", i));
      #1;
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_a_sel, fwd_b_sel, stall_count} !== e.val) begin
        miscompares++;
        $display("FAIL %s: got stall=%b a=%b b=%b cnt=%0d want stall=%b a=%b b=%b cnt=%0d",
                 e.name, stall, fwd_a_sel, fwd_b_sel, stall_count,
                 e.val[20], e.val[19:18], e.val[17:16], e.val[15:0]);
      end
      if (t[i].rst) exp_cnt = '0;
      else if (t[i].es) exp_cnt++;
    end
  endtask

  // add $3,$1,$2 ; or $7,$1,$2 ; sub $4,$3,$5 (producer one slot further away)
  task automatic test_gap();
    row_t t[$];
    exp_t e;
    t.push_back(mk(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(mk(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0, 0, 2'b00, 2'b00));
`ifdef HAZ_FWD_EN
    t.push_back(mk(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(idle(2'b10, 2'b00));
`else
    t.push_back(mk(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 1, 2'b00, 2'b00));
    t.push_back(mk(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(idle(2'b00, 2'b00));
`endif
    t.push_back(idle(2'b00, 2'b00));
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i], $sformatf("gap[%0d]", i));
      #1;
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_a_sel, fwd_b_sel, stall_count} !== e.val) begin
        miscompares++;
        $display("FAIL %s: got stall=%b a=%b b=%b cnt=%0d want stall=%b a=%b b=%b cnt=%0d",
                 e.name, stall, fwd_a_sel, fwd_b_sel, stall_count,
                 e.val[20], e.val[19:18], e.val[17:16], e.val[15:0]);
      end
      if (t[i].rst) exp_cnt = '0;
      else if (t[i].es) exp_cnt++;
    end
  endtask

  // addi $3,$1 ; addi $3,$1 ; or $5,$3,$3
  task automatic test_youngest();
    row_t t[$];
    exp_t e;
    t.push_back(mk(1, 5'd1, 5'd3, 1, 0, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(mk(1, 5'd1, 5'd3, 1, 0, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00));
`ifdef HAZ_FWD_EN
    t.push_back(mk(1, 5'd3, 5'd3, 1, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(idle(2'b01, 2'b01));
`else
    t.push_back(mk(1, 5'd3, 5'd3, 1, 1, 5'd5, 1, 0, 0, 1, 2'b00, 2'b00));
    t.push_back(mk(1, 5'd3, 5'd3, 1, 1, 5'd5, 1, 0, 0, 1, 2'b00, 2'b00));
    t.push_back(mk(1, 5'd3, 5'd3, 1, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(idle(2'b00, 2'b00));
`endif
    t.push_back(idle(2'b00, 2'b00));
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i], $sformatf("youngest[%0d]", i));
      #1;
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_a_sel, fwd_b_sel, stall_count} !== e.val) begin
        miscompares++;
        $display("FAIL %s: got stall=%b a=%b b=%b cnt=%0d want stall=%b a=%b b=%b cnt=%0d",
                 e.name, stall, fwd_a_sel, fwd_b_sel, stall_count,
                 e.val[20], e.val[19:18], e.val[17:16], e.val[15:0]);
      end
      if (t[i].rst) exp_cnt = '0;
      else if (t[i].es) exp_cnt++;
    end
  endtask

  // addi $0,$1,5 ; add $4,$0,$0 -- $0 never produces
  task automatic test_reg0();
    row_t t[$];
    exp_t e;
    t.push_back(mk(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(mk(1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(idle(2'b00, 2'b00));
    t.push_back(idle(2'b00, 2'b00));
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i], $sformatf("reg0[%0d]", i));
      #1;
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_a_sel, fwd_b_sel, stall_count} !== e.val) begin
        miscompares++;
        $display("FAIL %s: got stall=%b a=%b b=%b cnt=%0d want stall=%b a=%b b=%b cnt=%0d",
                 e.name, stall, fwd_a_sel, fwd_b_sel, stall_count,
                 e.val[20], e.val[19:18], e.val[17:16], e.val[15:0]);
      end
      if (t[i].rst) exp_cnt = '0;
      else if (t[i].es) exp_cnt++;
    end
  endtask

  // lw $3 ; add $4,$2,$3 flushed ; sub $5,$4,$4 must not see the flushed add
  task automatic test_flush();
    row_t t[$];
    exp_t e;
    t.push_back(mk(1, 5'd1, 5'd3, 1, 0, 5'd3, 1, 1, 0, 0, 2'b00, 2'b00));
    t.push_back(mk(1, 5'd2, 5'd3, 1, 1, 5'd4, 1, 0, 1, 0, 2'b00, 2'b00));
    t.push_back(mk(1, 5'd4, 5'd4, 1, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(idle(2'b00, 2'b00));
    t.push_back(idle(2'b00, 2'b00));
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i], $sformatf("flush[%0d]", i));
      #1;
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_a_sel, fwd_b_sel, stall_count} !== e.val) begin
        miscompares++;
        $display("FAIL %s: got stall=%b a=%b b=%b cnt=%0d want stall=%b a=%b b=%b cnt=%0d",
                 e.name, stall, fwd_a_sel, fwd_b_sel, stall_count,
                 e.val[20], e.val[19:18], e.val[17:16], e.val[15:0]);
      end
      if (t[i].rst) exp_cnt = '0;
      else if (t[i].es) exp_cnt++;
    end
  endtask

  // lw $3 ; add $4,$2,$3 with reset during the stall cycle
  task automatic test_reset_mid_stall();
    row_t t[$];
    row_t r;
    exp_t e;
    t.push_back(mk(1, 5'd1, 5'd3, 1, 0, 5'd3, 1, 1, 0, 0, 2'b00, 2'b00));
    r = mk(1, 5'd2, 5'd3, 1, 1, 5'd4, 1, 0, 0, 1, 2'b00, 2'b00);
    r.rst = 1'b1;
    t.push_back(r);
    t.push_back(mk(1, 5'd2, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00));
    t.push_back(idle(2'b00, 2'b00));
    t.push_back(idle(2'b00, 2'b00));
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i], $sformatf("reset_mid_stall[%0d]", i));
      #1;
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_a_sel, fwd_b_sel, stall_count} !== e.val) begin
        miscompares++;
        $display("FAIL %s: got stall=%b a=%b b=%b cnt=%0d want stall=%b a=%b b=%b cnt=%0d",
                 e.name, stall, fwd_a_sel, fwd_b_sel, stall_count,
                 e.val[20], e.val[19:18], e.val[17:16], e.val[15:0]);
      end
      if (t[i].rst) exp_cnt = '0;
      else if (t[i].es) exp_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_gap();
    test_youngest();
    test_reg0();
    test_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
